kyber_intt: RTL and testbench
=============================

// Module: kyber_intt
// PURPOSE
//  Inverse NTT for Kyber (n=256, q=3329). Companion to the forward NTT: same 128-bit/8-coefficient word stream and control handshake.
//  Loads a 256-coefficient NTT-domain polynomial, runs 8 Gentleman-Sande layers, optionally scales by n^-1, then streams the result out.
// PARAMETERS
//  none; all sizes come from the shared package (KYBER_N=256, KYBER_Q=3329, KYBER_N_INV=3316)
// PORTS
//  clk        in   1    single clock, rising edge
//  reset_n    in   1    asynchronous, active-low reset
//  start      in   1    begin a transform; sampled only in IDLE
//  valid_in   in   1    data_in valid; accepted when ready_in=1
//  data_in    in   128  coeffs 8w..8w+7, coeff 8w+i at bits [16i+:16], canonical [0,q)
//  ready_in   out  1    high during LOAD
//  data_out   out  128  output word, same packing as data_in
//  valid_out  out  1    data_out valid; one word per cycle, no backpressure
//  done       out  1    single-cycle pulse after the last output word
// BEHAVIOUR
//  Reset: state=IDLE. ready_in, valid_out, done, data_out=0. All counters=0. Coefficient RAM is not cleared.
//  FSM: IDLE -start-> LOAD -32nd word-> COMPUTE -last butterfly-> SCALE -256th coeff-> OUTPUT -32nd word-> DONE -> IDLE.
//   SCALE is skipped when KYBER_INTT_SCALE_EN is undefined: COMPUTE goes straight to OUTPUT.
//  IDLE: ready_in=0. start moves to LOAD; ready_in=1 from the next cycle.
//  LOAD: word index w counts 0..31 on valid_in&ready_in only; gaps in valid_in stall w.
//   Accepting w=31 drops ready_in in the same edge and enters COMPUTE.
//  COMPUTE: len = 128,64,...,1. Per len: block_base 0,2len,...; position p 0..len-1.
//   Each butterfly takes 2 cycles:
//   - cycle 0: read a=c[j], b=c[j+len], zinv=ROM[len-1+p], j=block_base+p.
//   - cycle 1: c[j]<=mod_add(a,b); c[j+len]<=barrett_reduce(mod_sub(a,b)*zinv).
//   - Product is 12b x 12b -> 24b unsigned before reduction.
//   1024 butterflies -> exactly 2048 cycles.
//  SCALE: one coeff per cycle, k=0..255: c[k]<=barrett_reduce(c[k]*KYBER_N_INV). Exactly 256 cycles.
//  OUTPUT: valid_out=1 for 32 consecutive cycles with words 0..31. DONE then pulses done for 1 cycle and returns to IDLE.
//  Latency: first valid_out is 2305 cycles after the edge accepting word 31 (2049 without scale). done follows the last word by 1 cycle.
//  Ordering: start outside IDLE is ignored. valid_in outside LOAD is ignored.
//  Ranges: all stored coeffs stay in [0,q). Inputs >= q are out of contract.
//  reset_n low at any time (mid-LOAD/COMPUTE/OUTPUT): outputs clear immediately and state=IDLE. A transform in progress is abandoned.
// CONFIGURATION
//  KYBER_INTT_SCALE_EN defined: SCALE state present; output = true inverse (INTT(NTT(x)) = x).
//  KYBER_INTT_SCALE_EN undefined: no SCALE state and no n^-1 multiplier; output = 256*x mod q.
//   For use when n^-1 is folded into a downstream Montgomery/pointwise stage.
// STRUCTURE
//  Shared package kyber_params.vh: KYBER_N, KYBER_Q, KYBER_N_INV (new, 3316 = 256^-1 mod 3329).
//  Shared package kyber_mod_functions.vh: barrett_reduce, mod_add, mod_sub (reused unchanged).
//  State encodings stay local to this module.
//  Sub-module zetas_inv_rom: combinational, 9-bit addr, 16-bit data, entries 0..254.
//   Entry k = modular inverse of the forward zetas_rom entry k.
//   Forward layer len uses base len-1, so zinv pairs exactly with the forward butterfly it undoes.
// TESTING
//  1 all-zero input -> 32 zero words. First valid_out exactly 2305 cycles after the last accept; done 1 cycle after word 31.
//  2 input all coeffs =1 -> output c[0]=1, rest 0 (SCALE_EN). Without macro: c[0]=256, rest 0.
//  3 input all coeffs =3328 -> output c[0]=3328, rest 0. Exercises mod_sub wrap and q-1 boundary.
//  4 round trip: 20 random polys through kyber_ntt then kyber_intt -> bit-exact original (SCALE_EN).
//  5 load with valid_in toggled 1/0 each cycle -> identical output to gap-free load. start pulsed during COMPUTE -> ignored.
//  6 reset_n asserted at cycle 1000 of COMPUTE -> outputs 0 and IDLE asynchronously. Next start + load of test 2 -> test 2 result.

Source files
------------

// File: rtl/kyber_intt_pkg.sv
// ---------------------------------------------------------------------------
// kyber_intt_pkg : Kyber ring constants and modular arithmetic helpers
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package kyber_intt_pkg;

    localparam int KYBER_N     = 256;
    localparam int KYBER_Q     = 3329;
    localparam int KYBER_N_INV = 3316;
    localparam int KYBER_ZETA  = 17;
    localparam int BARRETT_M   = 5039;  // floor(2^24 / q)

    typedef logic [11:0] coeff_t;

    // Valid for any x < 2^24; the quotient estimate is at most one short.
    function automatic coeff_t barrett_reduce(input logic [23:0] x);
        logic [36:0] prod;
        logic [12:0] quo;
        logic [23:0] quo_q;
        logic [12:0] rem;
        prod  = 37'(x) * 37'(BARRETT_M);
        quo   = 13'(prod >> 24);
        quo_q = 24'(quo) * 24'(KYBER_Q);
        rem   = 13'(x - quo_q);
        if (rem >= 13'(KYBER_Q)) rem = rem - 13'(KYBER_Q);
        return coeff_t'(rem);
    endfunction

    function automatic coeff_t mod_add(input coeff_t a, input coeff_t b);
        logic [12:0] sum;
        sum = 13'(a) + 13'(b);
        if (sum >= 13'(KYBER_Q)) sum = sum - 13'(KYBER_Q);
        return coeff_t'(sum);
    endfunction

    function automatic coeff_t mod_sub(input coeff_t a, input coeff_t b);
        logic [12:0] diff;
        if (a >= b) diff = 13'(a) - 13'(b);
        else        diff = 13'(a) + 13'(KYBER_Q) - 13'(b);
        return coeff_t'(diff);
    endfunction

    // Entry k sits in layer len (largest power of two <= k+1) at position
    // p = k+1-len; the forward twiddle is zeta^(p*128/len), this is its inverse.
    function automatic logic [15:0] zinv_entry(input int k);
        int len_v;
        int pos;
        int expo;
        int acc;
        len_v = 1;
        while (2 * len_v <= k + 1) len_v = 2 * len_v;
        pos  = k + 1 - len_v;
        expo = (256 - pos * (128 / len_v)) % 256;
        acc  = 1;
        for (int i = 0; i < expo; i++) acc = (acc * KYBER_ZETA) % KYBER_Q;
        return 16'(acc);
    endfunction

endpackage

`default_nettype wire

// File: rtl/kyber_intt_zetas_inv_rom.sv
// ---------------------------------------------------------------------------
// kyber_intt_zetas_inv_rom : combinational inverse-twiddle table, entries 0..254
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module kyber_intt_zetas_inv_rom (
    input  logic [8:0]  addr,
    output logic [15:0] data
);
    import kyber_intt_pkg::*;

    logic [15:0] rom_data [255];

    for (genvar k = 0; k < 255; k++) begin : g_entry
        localparam logic [15:0] ENTRY = zinv_entry(k);
        assign rom_data[k] = ENTRY;
    end

    assign data = (addr < 9'd255) ? rom_data[addr[7:0]] : 16'd0;

endmodule

`default_nettype wire

// File: rtl/kyber_intt.sv
// ---------------------------------------------------------------------------
// kyber_intt : 256-point Kyber inverse NTT, 8 coefficients per 128-bit word
// Optional n^-1 scaling pass enabled by macro KYBER_INTT_SCALE_EN.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module kyber_intt (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         valid_in,
    input  logic [127:0] data_in,
    output logic         ready_in,
    output logic [127:0] data_out,
    output logic         valid_out,
    output logic         done
);
    import kyber_intt_pkg::*;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_COMPUTE = 3'd2;
    localparam logic [2:0] S_OUTPUT  = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;
`ifdef KYBER_INTT_SCALE_EN
    localparam logic [2:0] S_SCALE   = 3'd3;
    localparam logic [2:0] S_POST_COMPUTE = S_SCALE;
`else
    localparam logic [2:0] S_POST_COMPUTE = S_OUTPUT;
`endif

    logic [2:0]   state;
    logic [2:0]   state_next;
    logic [10:0]  cnt;
    coeff_t       coeffs [KYBER_N];
    coeff_t       bf_a;
    coeff_t       bf_b;
    coeff_t       bf_z;
    logic         accept;
    logic         valid_out_next;
    logic         done_next;
    logic [127:0] word_next;
    logic [15:0]  zinv_data;
    logic [31:0]  unused_data_hi;
    logic [3:0]   unused_zinv_hi;

    // COMPUTE counter layout: {layer[2:0], butterfly[6:0], phase}
    logic       phase;
    logic [6:0] bf_idx;
    logic [2:0] layer;
    logic [7:0] len;
    logic [6:0] pos_mask;
    logic [6:0] pos;
    logic [7:0] idx_a;
    logic [7:0] idx_b;
    logic [8:0] zaddr;

    assign phase    = cnt[0];
    assign bf_idx   = cnt[7:1];
    assign layer    = cnt[10:8];
    assign len      = 8'd128 >> layer;
    assign pos_mask = 7'(len - 8'd1);
    assign pos      = bf_idx & pos_mask;
    assign idx_a    = {bf_idx & ~pos_mask, 1'b0} | {1'b0, pos};
    assign idx_b    = idx_a | len;
    assign zaddr    = 9'(len) - 9'd1 + 9'(pos);

    kyber_intt_zetas_inv_rom u_zetas_inv_rom (
        .addr (zaddr),
        .data (zinv_data)
    );

    assign unused_zinv_hi = zinv_data[15:12];
    assign accept         = valid_in & ready_in;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (start) state_next = S_LOAD;
            S_LOAD:    if (accept && cnt[4:0] == 5'd31) state_next = S_COMPUTE;
            S_COMPUTE: if (cnt == 11'd2047) state_next = S_POST_COMPUTE;
`ifdef KYBER_INTT_SCALE_EN
            S_SCALE:   if (cnt[7:0] == 8'd255) state_next = S_OUTPUT;
`endif
            S_OUTPUT:  if (cnt[4:0] == 5'd31) state_next = S_DONE;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ready_in       = (state == S_LOAD);
        valid_out_next = (state == S_OUTPUT);
        done_next      = (state == S_DONE);
        word_next      = '0;
        unused_data_hi = '0;
        for (int i = 0; i < 8; i++) begin
            word_next[16*i +: 16]     = {4'd0, coeffs[{cnt[4:0], 3'(i)}]};
            unused_data_hi[4*i +: 4]  = data_in[16*i+12 +: 4];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            bf_a      <= '0;
            bf_b      <= '0;
            bf_z      <= '0;
            valid_out <= 1'b0;
            done      <= 1'b0;
            data_out  <= '0;
        end else begin
            if (state_next != state)
                cnt <= '0;
            else if (state != S_IDLE && state != S_DONE && (state != S_LOAD || accept))
                cnt <= cnt + 11'd1;
            if (state == S_COMPUTE && !phase) begin
                bf_a <= coeffs[idx_a];
                bf_b <= coeffs[idx_b];
                bf_z <= zinv_data[11:0];
            end
            valid_out <= valid_out_next;
            done      <= done_next;
            data_out  <= valid_out_next ? word_next : '0;
        end
    end

    // Coefficient storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (state == S_LOAD && accept) begin
            for (int i = 0; i < 8; i++)
                coeffs[{cnt[4:0], 3'(i)}] <= data_in[16*i +: 12];
        end
        if (state == S_COMPUTE && phase) begin
            coeffs[idx_a] <= mod_add(bf_a, bf_b);
            coeffs[idx_b] <= barrett_reduce(24'(mod_sub(bf_a, bf_b)) * 24'(bf_z));
        end
`ifdef KYBER_INTT_SCALE_EN
        if (state == S_SCALE)
            coeffs[cnt[7:0]] <= barrett_reduce(24'(coeffs[cnt[7:0]]) * 24'(KYBER_N_INV));
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_kyber_intt.sv
// ---------------------------------------------------------------------------
// tb_kyber_intt : scoreboard bench for kyber_intt (round trip via a forward model)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_kyber_intt;

    localparam int Q = 3329;
`ifdef KYBER_INTT_SCALE_EN
    localparam int EXP_LAT = 2305;
`else
    localparam int EXP_LAT = 2049;
`endif

    typedef logic [11:0] poly_t [256];

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic         valid_in;
    logic [127:0] data_in;
    logic         ready_in;
    logic [127:0] data_out;
    logic         valid_out;
    logic         done;

    always #5 clk = ~clk;

    kyber_intt dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_in  (ready_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .done      (done)
    );

    int           checks   = 0;
    int           failures = 0;
    int           mon_cnt  = 0;
    logic [127:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int pow_mod(input int b, input int e);
        int r;
        r = 1;
        for (int i = 0; i < e; i++) r = (r * b) % Q;
        return r;
    endfunction

    // Cooley-Tukey forward transform whose layers the DUT undoes in reverse.
    function automatic poly_t fwd_ntt(input poly_t x);
        int    c [256];
        poly_t y;
        int    j;
        int    z;
        int    t;
        for (int i = 0; i < 256; i++) c[i] = int'(x[i]);
        for (int len = 1; len <= 128; len = len * 2)
            for (int base = 0; base < 256; base += 2 * len)
                for (int p = 0; p < len; p++) begin
                    j = base + p;
                    z = pow_mod(17, p * (128 / len));
                    t = (z * c[j + len]) % Q;
                    c[j + len] = (c[j] - t + Q) % Q;
                    c[j]       = (c[j] + t) % Q;
                end
        for (int i = 0; i < 256; i++) y[i] = 12'(c[i]);
        return y;
    endfunction

    function automatic poly_t scale_exp(input poly_t x);
        poly_t y;
        for (int i = 0; i < 256; i++) begin
`ifdef KYBER_INTT_SCALE_EN
            y[i] = x[i];
`else
            y[i] = 12'((256 * int'(x[i])) % Q);
`endif
        end
        return y;
    endfunction

    function automatic logic [127:0] pack_word(input poly_t p, input int w);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[16*i +: 16] = {4'd0, p[8*w + i]};
        return r;
    endfunction

    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_word", 128'(valid_out), 128'd0);
            end else begin
                check_eq($sformatf("data_out_w%0d", mon_cnt % 32), data_out, exp_q.pop_front());
                mon_cnt++;
            end
        end
    end

    task automatic pulse_reset();
        reset_n = 1'b0;
        #1;
        check_eq("rst_ready_in", 128'(ready_in), 128'd0);
        check_eq("rst_valid_out", 128'(valid_out), 128'd0);
        check_eq("rst_done", 128'(done), 128'd0);
        check_eq("rst_data_out", data_out, 128'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // abort_mode: 0 full run, 1 reset at COMPUTE cycle 1000, 2 reset at first output word
    task automatic run_transform(input poly_t in_poly, input poly_t exp_poly,
                                 input bit gapped, input bit glitch, input int abort_mode);
        int n;
        int burst;
        bit seen;
        if (abort_mode == 0)
            for (int w = 0; w < 32; w++) exp_q.push_back(pack_word(exp_poly, w));
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check_eq("ready_in_load", 128'(ready_in), 128'd1);
        for (int w = 0; w < 32; w++) begin
            if (gapped) begin
                @(posedge clk);
                #1;
            end
            valid_in = 1'b1;
            data_in  = pack_word(in_poly, w);
            @(posedge clk);
            #1 valid_in = 1'b0;
            data_in = '0;
        end
        check_eq("ready_in_after_load", 128'(ready_in), 128'd0);
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
            if (glitch && n == 100) begin
                start    = 1'b1;
                valid_in = 1'b1;
                data_in  = {128{1'b1}};
            end
            if (glitch && n == 101) begin
                start    = 1'b0;
                valid_in = 1'b0;
                data_in  = '0;
            end
            if (abort_mode == 1 && n == 1000) begin
                pulse_reset();
                return;
            end
            seen = valid_out;
        end
        check_eq("latency", 128'(n), 128'(EXP_LAT));
        if (!seen) return;
        if (abort_mode == 2) begin
            pulse_reset();
            return;
        end
        burst = 1;
        for (int i = 1; i < 32; i++) begin
            @(posedge clk);
            #1;
            if (valid_out) burst++;
        end
        check_eq("burst_len", 128'(burst), 128'd32);
        @(posedge clk);
        #1 check_eq("done_pulse", 128'({done, valid_out}), 128'b10);
        @(posedge clk);
        #1 check_eq("done_clear", 128'(done), 128'd0);
    endtask

    initial begin
        poly_t zero_p;
        poly_t ones_p;
        poly_t max_p;
        poly_t x;
        poly_t d;
        poly_t f;
        poly_t e;
        reset_n  = 1'b0;
        start    = 1'b0;
        valid_in = 1'b0;
        data_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_ready_in", 128'(ready_in), 128'd0);
        check_eq("reset_valid_out", 128'(valid_out), 128'd0);
        check_eq("reset_done", 128'(done), 128'd0);
        check_eq("reset_data_out", data_out, 128'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1 check_eq("idle_ready_in", 128'(ready_in), 128'd0);

        for (int i = 0; i < 256; i++) begin
            zero_p[i] = 12'd0;
            ones_p[i] = 12'd1;
            max_p[i]  = 12'd3328;
        end

        run_transform(zero_p, zero_p, 1'b0, 1'b0, 0);
        d = zero_p;
        d[0] = 12'd1;
        e = scale_exp(d);
        run_transform(ones_p, e, 1'b0, 1'b0, 0);
        d[0] = 12'd3328;
        e = scale_exp(d);
        run_transform(max_p, e, 1'b0, 1'b0, 0);

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 256; i++) x[i] = 12'($urandom_range(3328, 0));
            f = fwd_ntt(x);
            e = scale_exp(x);
            run_transform(f, e, 1'b0, 1'b0, 0);
        end
        run_transform(f, e, 1'b1, 1'b1, 0);

        d = zero_p;
        d[0] = 12'd1;
        e = scale_exp(d);
        run_transform(ones_p, zero_p, 1'b0, 1'b0, 1);
        run_transform(ones_p, e, 1'b0, 1'b0, 0);
        run_transform(ones_p, zero_p, 1'b0, 1'b0, 2);
        run_transform(ones_p, e, 1'b0, 1'b0, 0);

        repeat (3) @(posedge clk);
        #1 check_eq("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
